// File: rtl/aes_key_expand_if.sv
// Valid/ready stream bundle between the AES-128 key expander and its round controller.
// The controller drives start/key_in/rk_ready; the expander drives the rest.
interface aes_key_expand_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_round, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_round, done
  );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over a valid/ready stream.
// Optional AES_KEY_EXPAND_STORE_EN adds an 11-entry round-key store with a combinational read port.
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic           clk,
  input  logic           rst,
`ifdef AES_KEY_EXPAND_STORE_EN
  input  logic [3:0]     i_rd_idx,
  output logic [127:0]   o_rd_key,
`endif
  aes_key_expand_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

  state_t       r_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic [7:0]   r_rcon;
  logic         r_valid;
  logic         r_busy;
  logic         r_done;
  logic [127:0] w_next;
  logic         w_xfer;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5; 8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0; 8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc; 8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a; 8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0; 8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b; 8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85; 8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5; 8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17; 8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88; 8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c; 8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9; 8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6; 8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e; 8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94; 8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68; 8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb;
      // NOTE: a default arm keeps the function fully assigned, so no latch can be inferred.
      default: s = 8'h16;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One full key-schedule step: w0..w3 of round N+1 from round N.
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign w_next = next_key(r_key, r_rcon);
  assign w_xfer = r_valid & bus.rk_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_rcon  <= 8'h01;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FIN: begin
          r_done <= 1'b0;
          // A start arriving in FIN is taken immediately so back-to-back expansions lose no cycle.
          if (bus.start) begin
            r_key   <= bus.key_in;
            r_round <= '0;
            r_rcon  <= 8'h01;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= EMIT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        EMIT: begin
          if (w_xfer) begin
            if (r_round == 4'(NUM_ROUNDS)) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_key   <= w_next;
              r_round <= r_round + 4'd1;
              r_rcon  <= xtime(r_rcon);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rk_out   = r_key;
  assign bus.rk_round = r_round;
  assign bus.rk_valid = r_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

`ifdef AES_KEY_EXPAND_STORE_EN
  logic [127:0] r_store [0:NUM_ROUNDS];

  // NOTE: the store is small and must read back as zero after reset, so it is reset explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) r_store[i] <= '0;
    end else if (w_xfer) begin
      r_store[r_round] <= r_key;
    end
  end

  assign o_rd_key = (i_rd_idx > 4'(NUM_ROUNDS)) ? '0 : r_store[i_rd_idx];
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and all-zero key schedules, backpressure,
// start-while-busy, start-in-FIN, async reset abort, and the optional key store.
module tb_aes_key_expand;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_expand_if bus ();

`ifdef AES_KEY_EXPAND_STORE_EN
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key;
`endif

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
`ifdef AES_KEY_EXPAND_STORE_EN
    .i_rd_idx (rd_idx),
    .o_rd_key (rd_key),
`endif
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  logic [127:0] fips_rk  [0:10];
  logic [127:0] got_keys [0:10];

  typedef struct {
    logic [127:0] key;
    int           round;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Called at a negedge with the expander idle; captures all 11 keys with rk_ready held high.
  task automatic run_keys(input logic [127:0] key);
    bus.rk_ready = 1'b1;
    bus.key_in   = key;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      check($sformatf("run_valid_r%0d", r), 128'(bus.rk_valid), 128'd1);
      check($sformatf("run_round_r%0d", r), 128'(bus.rk_round), 128'(r));
      got_keys[r] = bus.rk_out;
      @(negedge clk);
    end
    check("run_done_pulse", 128'(bus.done), 128'd1);
    check("run_valid_low", 128'(bus.rk_valid), 128'd0);
    @(negedge clk);
    check("run_done_clear", 128'(bus.done), 128'd0);
    check("run_busy_low", 128'(bus.busy), 128'd0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(bus.done), 128'd1);
    @(negedge clk);
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    for (int i = 0; i <= 10; i++) vecs[i] = '{FIPS_KEY, i, fips_rk[i]};
    vecs[11] = '{ZERO_KEY, 0,  128'h0};
    vecs[12] = '{ZERO_KEY, 1,  128'h62636363626363636263636362636363};
    vecs[13] = '{ZERO_KEY, 2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    vecs[14] = '{ZERO_KEY, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;

    // Reset state
    #12;
    check("reset_valid", 128'(bus.rk_valid), 128'd0);
    check("reset_busy",  128'(bus.busy), 128'd0);
    check("reset_done",  128'(bus.done), 128'd0);
    check("reset_out",   bus.rk_out, 128'd0);
    check("reset_round", 128'(bus.rk_round), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven key schedules
    for (int i = 0; i < 15; i++) begin
      if (i == 0 || vecs[i].key !== vecs[i-1].key) run_keys(vecs[i].key);
      check($sformatf("vec%0d_round%0d", i, vecs[i].round), got_keys[vecs[i].round], vecs[i].exp);
    end

    // Backpressure: stall 3 cycles on round 1
    bus.rk_ready = 1'b1;
    bus.key_in   = FIPS_KEY;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("bp_round1", 128'(bus.rk_round), 128'd1);
    bus.rk_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold_key_c%0d", c), bus.rk_out, fips_rk[1]);
      check($sformatf("bp_hold_round_c%0d", c), 128'(bus.rk_round), 128'd1);
      check($sformatf("bp_hold_valid_c%0d", c), 128'(bus.rk_valid), 128'd1);
    end
    bus.rk_ready = 1'b1;
    for (int r = 2; r <= 10; r++) begin
      @(negedge clk);
      check($sformatf("bp_resume_round_r%0d", r), 128'(bus.rk_round), 128'(r));
      check($sformatf("bp_resume_key_r%0d", r), bus.rk_out, fips_rk[r]);
    end
    @(negedge clk);
    check("bp_done", 128'(bus.done), 128'd1);
    @(negedge clk);

    // start while busy is ignored; start in FIN is accepted
    bus.key_in = FIPS_KEY;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      check($sformatf("sb_key_r%0d", r), bus.rk_out, fips_rk[r]);
      bus.start  = (r == 4);
      bus.key_in = (r >= 4) ? ZERO_KEY : FIPS_KEY;
      @(negedge clk);
    end
    check("sb_fin_done", 128'(bus.done), 128'd1);
    bus.start  = 1'b1;
    bus.key_in = ZERO_KEY;
    @(negedge clk);
    bus.start = 1'b0;
    check("fin_start_valid", 128'(bus.rk_valid), 128'd1);
    check("fin_start_round", 128'(bus.rk_round), 128'd0);
    check("fin_start_key0",  bus.rk_out, ZERO_KEY);
    check("fin_start_busy",  128'(bus.busy), 128'd1);
    check("fin_start_done",  128'(bus.done), 128'd0);
    @(negedge clk);
    check("fin_start_key1", bus.rk_out, 128'h62636363626363636263636362636363);
    wait_done("fin_start_finish");

    // Asynchronous reset at round 6
    bus.key_in = FIPS_KEY;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("ar_round6", 128'(bus.rk_round), 128'd6);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 128'(bus.rk_valid), 128'd0);
    check("ar_busy",  128'(bus.busy), 128'd0);
    check("ar_done",  128'(bus.done), 128'd0);
    check("ar_out",   bus.rk_out, 128'd0);
    check("ar_round", 128'(bus.rk_round), 128'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ar_idle_valid", 128'(bus.rk_valid), 128'd0);
    run_keys(FIPS_KEY);
    check("ar_restart_r0",  got_keys[0], fips_rk[0]);
    check("ar_restart_r10", got_keys[10], fips_rk[10]);

`ifdef AES_KEY_EXPAND_STORE_EN
    rd_idx = 4'd1;  #1 check("store_idx1",  rd_key, fips_rk[1]);
    rd_idx = 4'd10; #1 check("store_idx10", rd_key, fips_rk[10]);
    rd_idx = 4'd0;  #1 check("store_idx0",  rd_key, fips_rk[0]);
    rd_idx = 4'd11; #1 check("store_idx11", rd_key, 128'h0);
    rd_idx = 4'd15; #1 check("store_idx15", rd_key, 128'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule generator sitting directly upstream of encrypt_round; supplies its 128-bit key input.
- Accepts a 128-bit cipher key, then emits round keys 0..10 in order, one per accepted transfer, over a valid/ready stream.
- A round controller consumes each key and applies it to the matching encrypt_round pass.
- Byte order is FIPS-197 column-major: key[127:120] is byte 0, and w0 = key[127:96].

Parameters:
NUM_ROUNDS, 10, index of the final round key emitted; fixed at 10 for AES-128 (other values unsupported).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  begin expansion of key_in; sampled only in IDLE
key_in  input  128  cipher key; captured on the accepted start cycle
busy  output  1  high from the cycle after accepted start until return to IDLE
rk_valid  output  1  rk_out / rk_round hold a valid round key
rk_ready  input  1  downstream accepts the key; transfer occurs when rk_valid && rk_ready
rk_out  output  128  current round key
rk_round  output  4  index of rk_out, 0..10
done  output  1  one-cycle pulse after round key 10 is transferred

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, rk_valid=0, done=0, rk_out=0, rk_round=0, rcon=8'h01. Reset mid-expansion aborts at once; no further keys are emitted.
- States: IDLE, EMIT, FIN.
- IDLE:
  - start=1 loads rk_out<=key_in, rk_round<=0, rcon<=8'h01, rk_valid<=1, busy<=1, then goes to EMIT.
  - Latency: start at edge T gives round 0 valid after T.
- EMIT:
  - On transfer with rk_round<10: rk_out<=next(rk_out, rcon), rk_round<=rk_round+1, rcon<=xtime(rcon). rk_valid stays 1.
  - On transfer with rk_round==10: rk_valid<=0, done<=1, go to FIN.
  - No transfer (rk_ready=0): rk_out, rk_round and rk_valid hold stable. rk_valid is never dropped while unaccepted.
- FIN: done<=0, busy<=0, go to IDLE. done is high for exactly one cycle.
- With rk_ready held at 1, the 11 keys appear on 11 consecutive cycles and done asserts the cycle after the last key.
- next():
  - temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'
  - The whole next key is computed combinationally in one cycle.
- RotWord: {b1,b2,b3,b0}. SubWord uses four instances of the AES forward S-box, implemented as a 256-entry case function local to the block.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36. xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
- start is ignored while busy. start in the same cycle the FSM enters IDLE from FIN is honoured.
- key_in is only sampled on the accepted start cycle; later changes have no effect.

Optional Feature:
- Macro: AES_KEY_EXPAND_STORE_EN.
- Defined:
  - Adds ports rd_idx (input, 4) and rd_key (output, 128).
  - Adds an 11x128 register array written with each key as it is transferred.
  - rd_key = array[rd_idx] combinationally. rd_idx>10 returns 128'h0.
  - The array is cleared by rst and is not cleared by start.
  - Supports reverse-order key access for decryption.
- Undefined: the ports and array are absent; behaviour is otherwise identical.

Test Plan:
- FIPS key, rk_ready=1: key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse -> round0=2b7e1516..., round1=a0fafe1788542cb123a339392a6c7605, round2=f2c295f27a96b9435935807a7359f67f, round10=d014f9a8c9ee2589e13f0cc8b6630ca6 on consecutive cycles. done pulses one cycle later; busy then falls.
- Zero key: key_in=0 -> round1=62636363626363636263636362636363, round10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: same FIPS key, rk_ready low for 3 cycles at round 1 -> rk_out holds a0fafe17... and rk_round=1 throughout. Sequence resumes unchanged, with no skipped or duplicated rounds.
- start while busy: second start with a different key at round 4 -> ignored; remaining keys match the first key. A start in the FIN cycle is accepted.
- Async reset at round 6 -> outputs reach reset values immediately without waiting for a clock. A new start then produces round 0 correctly.
- With AES_KEY_EXPAND_STORE_EN: after the FIPS run, rd_idx=1 gives a0fafe17..., rd_idx=10 gives d014f9a8..., rd_idx=11 gives 0.
